pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the decode stage: generates PC/IF-ID stall and IF-ID/ID-EX flush controls from

---
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode-stage pipeline sequencer.
// Produces stall/flush controls for the PC, IF/ID and ID/EX registers from
// load-use hazards, taken branches in EX and jumps/exceptions in ID. It also
// owns the interrupt admission FSM and a saturating count of stall cycles.
module pipe_hazard_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int PEND_TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_ext,
    input  logic             pc_super,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_exp,
    input  logic             id_irq,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rt,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             irq_to_id,
    output logic             irq_starve,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_INJECT  = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    localparam logic [7:0]       WAIT_MAX = 8'(PEND_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]             state_q, state_d;
    logic [7:0]             wait_q, wait_d;
    logic                   seen_super_q, seen_super_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic lu;
    logic irq_sync;
    logic safe;
    logic forced;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        lu = ex_memrd && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // Prioritised stall/flush decode; a taken branch makes the ID instruction
    // wrong-path, so its load-use hazard is irrelevant. Reset forces all low.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!reset) begin
            pc_stall = 1'b0;
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else if (id_jump || id_exp) begin
            ifid_flush = 1'b1;
        end
    end

    // Synchroniser shift and saturating stall counter next-state.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], irq_ext};
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign irq_sync  = sync_q[SYNC_STAGES-1];
    assign irq_to_id = (state_q == ST_INJECT);
    assign stall_cnt = stall_cnt_q;

    // Interrupt admission FSM: waits in PEND for a hazard-free user-mode slot,
    // or forces admission once the wait counter reaches the timeout.
    always_comb begin
        safe   = !ex_br_taken && !lu && !id_jump && !id_exp && !pc_super;
        forced = (wait_q == WAIT_MAX) && !ex_br_taken && !lu && !pc_super;

        state_d      = state_q;
        wait_d       = wait_q;
        seen_super_d = seen_super_q;
        irq_starve   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wait_d       = 8'd0;
                seen_super_d = 1'b0;
                if (irq_sync && !pc_super) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!irq_sync) begin
                    state_d = ST_IDLE;
                end else if (safe) begin
                    state_d = ST_INJECT;
                end else if (forced) begin
                    state_d    = ST_INJECT;
                    irq_starve = 1'b1;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_INJECT: begin
                // A taken branch flushes the injected slot; retry from PEND
                // keeping the accumulated wait.
                if (ex_br_taken) begin
                    state_d = ST_PEND;
                end else if (id_irq) begin
                    state_d      = ST_SERVICE;
                    seen_super_d = 1'b0;
                end
            end
            ST_SERVICE: begin
                // Handler entry raises pc_super; its later drop marks the return.
                if (pc_super) begin
                    seen_super_d = 1'b1;
                end else if (seen_super_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any pending request and clears the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= 8'd0;
            seen_super_q <= 1'b0;
            sync_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            wait_q       <= wait_d;
            seen_super_q <= seen_super_d;
            sync_q       <= sync_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// checked against a behavioural model of the hazard and interrupt rules.
module tb_pipe_hazard_ctrl;

    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int TO   = 63;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          irq_ext, pc_super, id_uses_rt, id_jump, id_exp, id_irq;
    logic          ex_memrd, ex_br_taken;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic          irq_to_id, irq_starve;
    logic [CW-1:0] stall_cnt;

    int checks;
    int failures;

    pipe_hazard_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(CW), .PEND_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .irq_ext(irq_ext), .pc_super(pc_super),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .id_exp(id_exp), .id_irq(id_irq), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
        .ex_br_taken(ex_br_taken), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .irq_to_id(irq_to_id),
        .irq_starve(irq_starve), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_PEND, M_INJ, M_SVC} mode_t;
    mode_t m_mode;
    int    m_wait;
    bit    m_seen;
    int    m_cnt;
    bit    m_hist[$];   // irq_ext history; element 0 is the synchronised value

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_wait = 0;
        m_seen = 1'b0;
        m_cnt  = 0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic bit m_lu();
        return ex_memrd && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_flush}
    function automatic logic [3:0] m_haz();
        if (!reset)             return 4'b0000;
        if (ex_br_taken)        return 4'b0011;
        if (m_lu())             return 4'b1101;
        if (id_jump || id_exp)  return 4'b0010;
        return 4'b0000;
    endfunction

    function automatic bit m_safe();
        return !ex_br_taken && !m_lu() && !id_jump && !id_exp && !pc_super;
    endfunction

    function automatic bit m_starve();
        return reset && (m_mode == M_PEND) && m_hist[0] && !m_safe() &&
               (m_wait == TO) && !ex_br_taken && !m_lu() && !pc_super;
    endfunction

    function automatic void model_step();
        logic [3:0] h;
        bit         sync;
        if (!reset) begin
            model_reset();
            return;
        end
        h    = m_haz();
        sync = m_hist[0];
        if (h[3] && m_cnt < CMAX) m_cnt = m_cnt + 1;
        case (m_mode)
            M_IDLE: if (sync && !pc_super) begin m_mode = M_PEND; m_wait = 0; end
            M_PEND: begin
                if (!sync)            m_mode = M_IDLE;
                else if (m_safe())    m_mode = M_INJ;
                else if (m_starve())  m_mode = M_INJ;
                else if (m_wait < TO) m_wait = m_wait + 1;
            end
            M_INJ: begin
                if (ex_br_taken) m_mode = M_PEND;
                else if (id_irq) begin m_mode = M_SVC; m_seen = 1'b0; end
            end
            M_SVC: begin
                if (pc_super)    m_seen = 1'b1;
                else if (m_seen) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
        m_hist.push_back(irq_ext);
        void'(m_hist.pop_front());
    endfunction

    // One clock: the model samples inputs at the edge, inputs change 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        pc_super = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
        id_exp = 0; id_irq = 0; ex_memrd = 0; ex_rt = 0; ex_br_taken = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush, irq_to_id, irq_starve} !== 6'b0 ||
            stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b cnt=%0d exp=000000 cnt=0",
                     {pc_stall, ifid_stall, ifid_flush, idex_flush, irq_to_id, irq_starve}, stall_cnt);
        end
        ex_memrd = 1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_masks_stall got=%b exp=0", pc_stall);
        end
        tick(); tick();
        checks++;
        if (stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_cnt_held got=%0d exp=0", stall_cnt);
        end
        clear_inputs();
        reset = 1'b1;
        tick();
        checks++;
        if (irq_to_id !== 1'b0 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_release got irq=%b cnt=%0d exp irq=0 cnt=0", irq_to_id, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        ex_memrd = 1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1101 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL lu_rs got=%b cnt=%0d exp=1101 cnt=0",
                     {pc_stall, ifid_stall, ifid_flush, idex_flush}, stall_cnt);
        end
        tick();
        ex_memrd = 0;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000 || stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL lu_one_bubble got=%b cnt=%0d exp=0000 cnt=1",
                     {pc_stall, ifid_stall, ifid_flush, idex_flush}, stall_cnt);
        end
        ex_memrd = 1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1101) begin
            failures++;
            $display("FAIL lu_rt got=%b exp=1101", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        id_uses_rt = 0;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000) begin
            failures++;
            $display("FAIL lu_rt_unused got=%b exp=0000", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        ex_memrd = 1; ex_rt = 5'd8; id_rs = 5'd8; ex_br_taken = 1; id_jump = 1;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0011) begin
            failures++;
            $display("FAIL br_over_lu got=%b exp=0011", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL br_cnt_kept got=%0d exp=1", stall_cnt);
        end
        ex_br_taken = 0;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1101) begin
            failures++;
            $display("FAIL lu_over_jump got=%b exp=1101", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0010) begin
            failures++;
            $display("FAIL r0_no_stall got=%b exp=0010", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        id_jump = 0; id_exp = 1;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0010) begin
            failures++;
            $display("FAIL exp_flush got=%b exp=0010", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        clear_inputs();
        tick();
    endtask

    task automatic finish_service();
        id_irq = 1;
        tick();
        id_irq = 0; irq_ext = 0; pc_super = 1;
        tick();
        pc_super = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_irq_admit();
        int first;
        irq_ext = 1;
        first = -1;
        for (int k = 1; k <= SYNC + 3; k++) begin
            tick();
            if (irq_to_id === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != SYNC + 2) begin
            failures++;
            $display("FAIL irq_latency got=%0d exp=%0d", first, SYNC + 2);
        end
        id_irq = 1;
        tick();
        id_irq = 0;
        tick(); tick(); tick();
        checks++;
        if (irq_to_id !== 1'b0) begin
            failures++;
            $display("FAIL svc_no_readmit got=%b exp=0", irq_to_id);
        end
        pc_super = 1;
        tick();
        pc_super = 0;
        tick();   // handler return: back to IDLE
        tick();   // IDLE -> PEND with irq still asserted
        tick();   // PEND -> INJECT
        checks++;
        if (irq_to_id !== 1'b1) begin
            failures++;
            $display("FAIL svc_return_readmit got=%b exp=1", irq_to_id);
        end
        ex_br_taken = 1;
        tick();
        ex_br_taken = 0;
        #1;
        checks++;
        if (irq_to_id !== 1'b0) begin
            failures++;
            $display("FAIL br_in_inject got=%b exp=0", irq_to_id);
        end
        tick();
        checks++;
        if (irq_to_id !== 1'b1) begin
            failures++;
            $display("FAIL reinject_after_br got=%b exp=1", irq_to_id);
        end
        finish_service();
    endtask

    task automatic test_starve();
        int pulses, pulse_at, inj_at;
        irq_ext = 1; id_jump = 1;
        pulses = 0; pulse_at = -1; inj_at = -1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (irq_starve === 1'b1) begin pulses++; pulse_at = k; end
            if (irq_to_id === 1'b1 && inj_at < 0) inj_at = k;
        end
        // Edges 1..SYNC fill the synchroniser, the next enters PEND, then
        // TO more edges raise the wait counter to the timeout.
        checks++;
        if (pulses != 1 || pulse_at != SYNC + 1 + TO) begin
            failures++;
            $display("FAIL starve_pulse got=%0d@%0d exp=1@%0d", pulses, pulse_at, SYNC + 1 + TO);
        end
        checks++;
        if (inj_at != SYNC + 2 + TO || irq_to_id !== 1'b1) begin
            failures++;
            $display("FAIL forced_inject got=%0d exp=%0d", inj_at, SYNC + 2 + TO);
        end
        id_jump = 0;
        finish_service();
    endtask

    task automatic test_stall_sat();
        pulse_reset();
        ex_memrd = 1; ex_rt = 5'd5; id_rs = 5'd5;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14 || n == 15 || n == 16 || n == 20) begin
                checks++;
                if (stall_cnt !== CW'((n < CMAX) ? n : CMAX)) begin
                    failures++;
                    $display("FAIL stall_sat n=%0d got=%0d exp=%0d", n, stall_cnt, (n < CMAX) ? n : CMAX);
                end
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        int first;
        irq_ext = 1;
        for (int k = 1; k <= SYNC + 2; k++) tick();
        ex_memrd = 1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        checks++;
        if (irq_to_id !== 1'b1 || pc_stall !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got irq=%b stall=%b exp irq=1 stall=1", irq_to_id, pc_stall);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush, irq_to_id, irq_starve} !== 6'b0 ||
            stall_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b cnt=%0d exp=000000 cnt=0",
                     {pc_stall, ifid_stall, ifid_flush, idex_flush, irq_to_id, irq_starve}, stall_cnt);
        end
        clear_inputs();
        tick(); tick();
        reset = 1'b1;
        first = -1;
        for (int k = 1; k <= SYNC + 3; k++) begin
            tick();
            if (irq_to_id === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != SYNC + 2) begin
            failures++;
            $display("FAIL post_reset_latency got=%0d exp=%0d", first, SYNC + 2);
        end
        finish_service();
    endtask

    task automatic test_random();
        pulse_reset();
        irq_ext = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) irq_ext = ~irq_ext;
            if ($urandom_range(11) == 0) pc_super = ~pc_super;
            ex_memrd    = ($urandom_range(2) == 0);
            ex_rt       = 5'($urandom_range(3));
            id_rs       = 5'($urandom_range(3));
            id_rt       = 5'($urandom_range(3));
            id_uses_rt  = 1'($urandom_range(1));
            id_jump     = ($urandom_range(7) == 0);
            id_exp      = ($urandom_range(15) == 0);
            id_irq      = ($urandom_range(3) == 0);
            ex_br_taken = ($urandom_range(7) == 0);
            #1;
            checks++;
            if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== m_haz()) begin
                failures++;
                $display("FAIL rnd_haz c=%0d got=%b exp=%b", c,
                         {pc_stall, ifid_stall, ifid_flush, idex_flush}, m_haz());
            end
            checks++;
            if (irq_to_id !== (m_mode == M_INJ) || irq_starve !== m_starve()) begin
                failures++;
                $display("FAIL rnd_irq c=%0d got=%b%b exp=%b%b", c, irq_to_id, irq_starve,
                         (m_mode == M_INJ), m_starve());
            end
            checks++;
            if (stall_cnt !== CW'(m_cnt)) begin
                failures++;
                $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt);
            end
            tick();
        end
        clear_inputs();
        irq_ext = 0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; irq_ext = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_priority();
        test_irq_admit();
        test_starve();
        test_stall_sat();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
